cbi980_axil_regbridge: RTL

- Parametrised AXI4-Lite slave that bridges to a simple single-port register bus (req/ack) inside the CBI980 I2S controller.
- Successor to the fixed 32-bit front end. Adds:
  - independent AW/W acceptance
  - byte strobes
  - range and privilege checking with SLVERR
  - read/write arbitration onto one backend port
  - backend timeout
- Sits between the SoC interconnect and the per-channel I2S register file.

---
 rtl/cbi980_axil_pkg.sv | 23 ++
 rtl/cbi980_axil_arb.sv | 42 ++++
 rtl/cbi980_axil_regbridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cbi980_axil_pkg.sv
// Shared constants, FSM encoding and helpers for the CBI980 AXI4-Lite register bridge.
package cbi980_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cbi980_axil_arb.sv
// Two-requester arbiter: write/read share one backend port; the grant is held until done.
module cbi980_axil_arb (
    input  logic clk,
    input  logic rst,
    input  logic req_w,
    input  logic req_r,
    input  logic done,
    output logic gnt_w_c,
    output logic gnt_r_c
);

    logic busy;
    logic last_w;

    // Grants only while the port is free; a tie goes to whoever lost the last tie.
    always_comb begin
        gnt_w_c = 1'b0;
        gnt_r_c = 1'b0;
        if (!busy) begin
            if (req_w && req_r) begin
                gnt_w_c = !last_w;
                gnt_r_c = last_w;
            end else begin
                gnt_w_c = req_w;
                gnt_r_c = req_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            last_w <= 1'b0;
        end else if (!busy) begin
            if (gnt_w_c || gnt_r_c) busy <= 1'b1;
            if (req_w && req_r) last_w <= gnt_w_c;
        end else if (done) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/cbi980_axil_regbridge.sv
// AXI4-Lite slave bridging to the single-port req/ack register bus of the CBI980 I2S controller.
module cbi980_axil_regbridge
    import cbi980_axil_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned REQ_PRIV = 0
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic [ADDR_W-1:0]         awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_W-1:0]         araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      reg_req,
    output logic                      reg_we,
    output logic [clog2(NREGS)-1:0]   reg_addr,
    output logic [DATA_W-1:0]         reg_wdata,
    output logic [DATA_W/8-1:0]       reg_wstrb,
    input  logic                      reg_ack,
    input  logic [DATA_W-1:0]         reg_rdata,
    input  logic                      reg_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = clog2(STRB_W);
    localparam int unsigned IDX_W  = clog2(NREGS);
    localparam int unsigned WINDOW = NREGS * STRB_W;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

    logic              aw_full, w_full, ar_full;
    logic              aw_full_n, w_full_n, ar_full_n;
    logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic              aw_priv_q, ar_priv_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [CNT_W-1:0]  to_cnt;

    state_t w_state, w_state_n, r_state, r_state_n;

    logic aw_hs, w_hs, ar_hs, b_done, r_done;
    logic w_pend, r_pend, w_bad, r_bad, req_w, req_r;
    logic gnt_w_c, gnt_r_c;
    logic to_hit, bk_done;
    logic [1:0] rsp_c;
    logic unused_prot;

    function automatic logic bad_access(input logic [ADDR_W-1:0] addr, input logic priv);
        return (addr >= ADDR_W'(WINDOW)) || ((REQ_PRIV != 0) && !priv);
    endfunction

    assign unused_prot = ^{awprot[2:1], arprot[2:1]};

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign b_done = bvalid && bready;
    assign r_done = rvalid && rready;

    // Holders stay full from capture until their response handshake completes.
    assign aw_full_n = (aw_full || aw_hs) && !b_done;
    assign w_full_n  = (w_full || w_hs) && !b_done;
    assign ar_full_n = (ar_full || ar_hs) && !r_done;

    assign w_pend = aw_full && w_full && (w_state == ST_IDLE);
    assign r_pend = ar_full && (r_state == ST_IDLE);
    assign w_bad  = bad_access(aw_addr_q, aw_priv_q);
    assign r_bad  = bad_access(ar_addr_q, ar_priv_q);
    assign req_w  = w_pend && !w_bad;
    assign req_r  = r_pend && !r_bad;

    assign to_hit  = (TIMEOUT != 0) && reg_req && !reg_ack && (to_cnt == CNT_W'(TIMEOUT - 1));
    assign bk_done = (reg_req && reg_ack) || to_hit;
    assign rsp_c   = (to_hit || reg_err) ? RESP_SLVERR : RESP_OKAY;

    cbi980_axil_arb u_arb (
        .clk     (aclk),
        .rst     (arst),
        .req_w   (req_w),
        .req_r   (req_r),
        .done    (bk_done),
        .gnt_w_c (gnt_w_c),
        .gnt_r_c (gnt_r_c)
    );

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            w_state <= ST_IDLE;
            r_state <= ST_IDLE;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        r_state_n = r_state;
        case (w_state)
            ST_IDLE: if (w_pend && w_bad) w_state_n = ST_RESP;
                     else if (gnt_w_c)    w_state_n = ST_REQ;
            ST_REQ:  if (bk_done)         w_state_n = ST_RESP;
            ST_RESP: if (b_done)          w_state_n = ST_IDLE;
            default:                      w_state_n = ST_IDLE;
        endcase
        case (r_state)
            ST_IDLE: if (r_pend && r_bad) r_state_n = ST_RESP;
                     else if (gnt_r_c)    r_state_n = ST_REQ;
            ST_REQ:  if (bk_done)         r_state_n = ST_RESP;
            ST_RESP: if (r_done)          r_state_n = ST_IDLE;
            default:                      r_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            arready   <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            aw_priv_q <= 1'b0;
            ar_priv_q <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
            to_cnt    <= '0;
        end else begin
            aw_full <= aw_full_n;
            w_full  <= w_full_n;
            ar_full <= ar_full_n;
            awready <= !aw_full_n;
            wready  <= !w_full_n;
            arready <= !ar_full_n;
            if (aw_hs) begin
                aw_addr_q <= awaddr;
                aw_priv_q <= awprot[0];
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (ar_hs) begin
                ar_addr_q <= araddr;
                ar_priv_q <= arprot[0];
            end

            // Entering RESP straight from IDLE means the access was rejected at decode.
            if (w_state_n == ST_RESP && w_state != ST_RESP) begin
                bvalid <= 1'b1;
                bresp  <= (w_state == ST_IDLE) ? RESP_SLVERR : rsp_c;
            end else if (b_done) begin
                bvalid <= 1'b0;
            end
            if (r_state_n == ST_RESP && r_state != ST_RESP) begin
                rvalid <= 1'b1;
                rresp  <= (r_state == ST_IDLE) ? RESP_SLVERR : rsp_c;
                rdata  <= (r_state == ST_IDLE || rsp_c != RESP_OKAY) ? '0 : reg_rdata;
            end else if (r_done) begin
                rvalid <= 1'b0;
            end

            if (gnt_w_c) begin
                reg_req   <= 1'b1;
                reg_we    <= 1'b1;
                reg_addr  <= aw_addr_q[IDX_W+LSB-1:LSB];
                reg_wdata <= w_data_q;
                reg_wstrb <= w_strb_q;
                to_cnt    <= '0;
            end else if (gnt_r_c) begin
                reg_req   <= 1'b1;
                reg_we    <= 1'b0;
                reg_addr  <= ar_addr_q[IDX_W+LSB-1:LSB];
                reg_wstrb <= '0;
                to_cnt    <= '0;
            end else if (bk_done) begin
                reg_req <= 1'b0;
            end else if (reg_req) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
        end
    end

endmodule
